mem_port_arbiter: RTL and testbench

- Shares one unified memory port between the pipeline's instruction fetch (IF) and data access (MEM stage) requesters.
- Sits between the cpu and the memory model or cache, and returns a per-requester BUSYWAIT so the pipeline stalls while the port is held by the other side.
- Data requests have priority by default. A streak counter bounds instruction starvation.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_port_arbiter_if.sv | 42 ++++
 rtl/mem_arb_streak_counter.sv | 35 +++
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants for the IF/MEM unified memory port arbiter: state encoding,
// default fetch read code and control-bus enable bit positions.
package mem_arb_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_I_ISSUE = 3'd1;
  localparam logic [2:0] ST_I_WAIT  = 3'd2;
  localparam logic [2:0] ST_D_ISSUE = 3'd3;
  localparam logic [2:0] ST_D_WAIT  = 3'd4;

  typedef enum logic [2:0] {
    StIdle   = ST_IDLE,
    StIIssue = ST_I_ISSUE,
    StIWait  = ST_I_WAIT,
    StDIssue = ST_D_ISSUE,
    StDWait  = ST_D_WAIT
  } arb_state_e;

  localparam logic [3:0] IF_READ_CODE_DEF = 4'b1010;

  localparam int unsigned READ_EN_BIT  = 3;
  localparam int unsigned WRITE_EN_BIT = 2;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, data and memory-side buses of the arbiter.
// slave = arbiter view; master = cpu + memory environment view.
interface mem_port_arbiter_if;

  logic        INSTR_READ;
  logic [31:0] INSTR_ADDR;
  logic [31:0] INSTR_DATA;
  logic        INSTR_MEM_BUSYWAIT;

  logic [3:0]  DATA_MEM_READ;
  logic [2:0]  DATA_MEM_WRITE;
  logic [31:0] DATA_MEM_ADDR;
  logic [31:0] DATA_MEM_WRITE_DATA;
  logic [31:0] DATA_MEM_READ_DATA;
  logic        DATA_MEM_BUSYWAIT;

  logic [3:0]  MEM_READ;
  logic [2:0]  MEM_WRITE;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_WRITE_DATA;
  logic [31:0] MEM_READ_DATA;
  logic        MEM_BUSYWAIT;

  modport slave (
    input  INSTR_READ, INSTR_ADDR,
    output INSTR_DATA, INSTR_MEM_BUSYWAIT,
    input  DATA_MEM_READ, DATA_MEM_WRITE, DATA_MEM_ADDR, DATA_MEM_WRITE_DATA,
    output DATA_MEM_READ_DATA, DATA_MEM_BUSYWAIT,
    output MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WRITE_DATA,
    input  MEM_READ_DATA, MEM_BUSYWAIT
  );

  modport master (
    output INSTR_READ, INSTR_ADDR,
    input  INSTR_DATA, INSTR_MEM_BUSYWAIT,
    output DATA_MEM_READ, DATA_MEM_WRITE, DATA_MEM_ADDR, DATA_MEM_WRITE_DATA,
    input  DATA_MEM_READ_DATA, DATA_MEM_BUSYWAIT,
    input  MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WRITE_DATA,
    output MEM_READ_DATA, MEM_BUSYWAIT
  );

endinterface

// File: rtl/mem_arb_streak_counter.sv
// Saturating count of consecutive data grants made while a fetch is waiting.
module mem_arb_streak_counter #(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam logic [3:0] MaxCount = 4'(MAX_D_STREAK);

  logic [3:0] count_q, count_d;

  assign at_max = (count_q == MaxCount);

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !at_max) begin
      count_d = count_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch and data access, data first
// with bounded fetch starvation. Optional stall counters: MEM_ARB_PERF_CNT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = 4,
  parameter logic [3:0]  IF_READ_CODE = IF_READ_CODE_DEF
) (
  input  logic               CLK,
  input  logic               RESET,
  mem_port_arbiter_if.slave  bus
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]        PERF_I_STALL,
  output logic [31:0]        PERF_D_STALL
`endif
);

  arb_state_e state_q, state_d;

  logic        i_req, d_req;
  logic        i_done_q, d_done_q;
  logic        grant_i, grant_d;
  logic        i_complete, d_complete;
  logic        at_max;
  logic [3:0]  mem_read_q;
  logic [2:0]  mem_write_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [31:0] instr_data_q, data_rdata_q;

  assign i_req = bus.INSTR_READ;
  assign d_req = bus.DATA_MEM_READ[READ_EN_BIT] | bus.DATA_MEM_WRITE[WRITE_EN_BIT];

  assign bus.INSTR_MEM_BUSYWAIT = i_req & ~i_done_q;
  assign bus.DATA_MEM_BUSYWAIT  = d_req & ~d_done_q;

  assign bus.MEM_READ           = mem_read_q;
  assign bus.MEM_WRITE          = mem_write_q;
  assign bus.MEM_ADDR           = mem_addr_q;
  assign bus.MEM_WRITE_DATA     = mem_wdata_q;
  assign bus.INSTR_DATA         = instr_data_q;
  assign bus.DATA_MEM_READ_DATA = data_rdata_q;

  assign i_complete = (state_q == StIWait) && !bus.MEM_BUSYWAIT;
  assign d_complete = (state_q == StDWait) && !bus.MEM_BUSYWAIT;

  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    case (state_q)
      StIdle: begin
        // The done cycle is a turnaround: the finished requester still shows its old
        // request, so nobody is granted until it has had a chance to advance.
        if (!i_done_q && !d_done_q) begin
          if (d_req && !(i_req && at_max)) begin
            grant_d = 1'b1;
            state_d = StDIssue;
          end else if (i_req) begin
            grant_i = 1'b1;
            state_d = StIIssue;
          end
        end
      end
      StIIssue: state_d = StIWait;
      StIWait:  if (!bus.MEM_BUSYWAIT) state_d = StIdle;
      StDIssue: state_d = StDWait;
      StDWait:  if (!bus.MEM_BUSYWAIT) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= StIdle;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      mem_read_q   <= '0;
      mem_write_q  <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      instr_data_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q  <= state_d;
      i_done_q <= i_complete;
      d_done_q <= d_complete;
      if (grant_i) begin
        mem_addr_q  <= bus.INSTR_ADDR;
        mem_read_q  <= IF_READ_CODE;
        mem_write_q <= '0;
        mem_wdata_q <= '0;
      end else if (grant_d) begin
        mem_addr_q  <= bus.DATA_MEM_ADDR;
        mem_wdata_q <= bus.DATA_MEM_WRITE_DATA;
        if (bus.DATA_MEM_WRITE[WRITE_EN_BIT]) begin
          mem_read_q  <= '0;
          mem_write_q <= bus.DATA_MEM_WRITE;
        end else begin
          mem_read_q  <= bus.DATA_MEM_READ;
          mem_write_q <= '0;
        end
      end else if (i_complete || d_complete) begin
        mem_read_q  <= '0;
        mem_write_q <= '0;
      end
      if (i_complete) begin
        instr_data_q <= bus.MEM_READ_DATA;
      end
      // Stores leave the load data register untouched.
      if (d_complete && mem_read_q[READ_EN_BIT]) begin
        data_rdata_q <= bus.MEM_READ_DATA;
      end
    end
  end

  mem_arb_streak_counter #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_streak (
    .clk   (CLK),
    .rst_n (RESET),
    .inc   (grant_d & i_req),
    .clr   (grant_i | (grant_d & ~i_req)),
    .at_max(at_max)
  );

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] perf_i_q, perf_d_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      perf_i_q <= '0;
      perf_d_q <= '0;
    end else begin
      if (bus.INSTR_MEM_BUSYWAIT) perf_i_q <= perf_i_q + 32'd1;
      if (bus.DATA_MEM_BUSYWAIT)  perf_d_q <= perf_d_q + 32'd1;
    end
  end

  assign PERF_I_STALL = perf_i_q;
  assign PERF_D_STALL = perf_d_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, data priority, starvation bound, slow store,
// flush and mid-transaction reset, each with hand-computed expectations.
module tb_mem_port_arbiter;

  logic clk;
  logic rst_n;
  int   passes;
  int   total;

  mem_port_arbiter_if bus ();

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] perf_i, perf_d;
`endif

  mem_port_arbiter #(
    .MAX_D_STREAK(4),
    .IF_READ_CODE(4'b1010)
  ) dut (
    .CLK  (clk),
    .RESET(rst_n),
    .bus  (bus)
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    .PERF_I_STALL(perf_i),
    .PERF_D_STALL(perf_d)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    logic [31:0] grants [8];
    int          n_grants;
    logic [3:0]  prev_rd;

    passes = 0;
    total  = 0;
    rst_n  = 1'b0;
    bus.INSTR_READ          = 1'b0;
    bus.INSTR_ADDR          = '0;
    bus.DATA_MEM_READ       = '0;
    bus.DATA_MEM_WRITE      = '0;
    bus.DATA_MEM_ADDR       = '0;
    bus.DATA_MEM_WRITE_DATA = '0;
    bus.MEM_READ_DATA       = '0;
    bus.MEM_BUSYWAIT        = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_mem_read", 32'(bus.MEM_READ), 32'h0);
    chk("rst_mem_write", 32'(bus.MEM_WRITE), 32'h0);
    chk("rst_mem_addr", bus.MEM_ADDR, 32'h0);
    chk("rst_instr_data", bus.INSTR_DATA, 32'h0);
    chk("rst_data_rdata", bus.DATA_MEM_READ_DATA, 32'h0);
    rst_n = 1'b1;

    // 1. Lone fetch, zero-wait memory
    bus.INSTR_READ    = 1'b1;
    bus.INSTR_ADDR    = 32'h40;
    bus.MEM_READ_DATA = 32'h0050_0093;
    #1;
    chk("t1_ibusy_req", 32'(bus.INSTR_MEM_BUSYWAIT), 32'h1);
    tick();
    chk("t1_mem_read", 32'(bus.MEM_READ), 32'hA);
    chk("t1_mem_addr", bus.MEM_ADDR, 32'h40);
    tick();
    chk("t1_ibusy_c2", 32'(bus.INSTR_MEM_BUSYWAIT), 32'h1);
    tick();
    chk("t1_ibusy_c3", 32'(bus.INSTR_MEM_BUSYWAIT), 32'h0);
    chk("t1_instr_data", bus.INSTR_DATA, 32'h0050_0093);
    chk("t1_mem_read_clr", 32'(bus.MEM_READ), 32'h0);
    bus.INSTR_READ = 1'b0;
    tick();

    // 2. Simultaneous fetch and load: data first
    bus.INSTR_READ    = 1'b1;
    bus.INSTR_ADDR    = 32'h80;
    bus.DATA_MEM_READ = 4'b1000;
    bus.DATA_MEM_ADDR = 32'h100;
    bus.MEM_READ_DATA = 32'hDEAD_BEEF;
    tick();
    chk("t2_grant_addr", bus.MEM_ADDR, 32'h100);
    chk("t2_grant_read", 32'(bus.MEM_READ), 32'h8);
    chk("t2_ibusy_g", 32'(bus.INSTR_MEM_BUSYWAIT), 32'h1);
    tick();
    chk("t2_ibusy_w", 32'(bus.INSTR_MEM_BUSYWAIT), 32'h1);
    tick();
    chk("t2_dbusy_done", 32'(bus.DATA_MEM_BUSYWAIT), 32'h0);
    chk("t2_data_rdata", bus.DATA_MEM_READ_DATA, 32'hDEAD_BEEF);
    chk("t2_ibusy_done", 32'(bus.INSTR_MEM_BUSYWAIT), 32'h1);
    bus.DATA_MEM_READ = 4'b0000;
    bus.MEM_READ_DATA = 32'h1111_1111;
    tick();
    chk("t2_ibusy_turn", 32'(bus.INSTR_MEM_BUSYWAIT), 32'h1);
    tick();
    chk("t2_fetch_addr", bus.MEM_ADDR, 32'h80);
    chk("t2_fetch_read", 32'(bus.MEM_READ), 32'hA);
    tick();
    tick();
    chk("t2_ibusy_end", 32'(bus.INSTR_MEM_BUSYWAIT), 32'h0);
    chk("t2_instr_data", bus.INSTR_DATA, 32'h1111_1111);
    bus.INSTR_READ = 1'b0;
    tick();

    // 3. Starvation bound: D D D D I D
    bus.INSTR_READ    = 1'b1;
    bus.INSTR_ADDR    = 32'h300;
    bus.DATA_MEM_READ = 4'b1000;
    bus.DATA_MEM_ADDR = 32'h200;
    bus.MEM_READ_DATA = 32'hA5A5_A5A5;
    n_grants = 0;
    prev_rd  = bus.MEM_READ;
    for (int c = 0; c < 24; c++) begin
      tick();
      if (bus.MEM_READ != 4'b0000 && prev_rd == 4'b0000 && n_grants < 8) begin
        grants[n_grants] = bus.MEM_ADDR;
        n_grants++;
      end
      prev_rd = bus.MEM_READ;
    end
    chk("t3_n_grants", 32'(n_grants), 32'd6);
    chk("t3_g0", grants[0], 32'h200);
    chk("t3_g3", grants[3], 32'h200);
    chk("t3_g4_fetch", grants[4], 32'h300);
    chk("t3_g5_data", grants[5], 32'h200);
    bus.INSTR_READ    = 1'b0;
    bus.DATA_MEM_READ = 4'b0000;
    tick();
    tick();

    // 4. Store with 5 wait cycles; write wins over read
    bus.DATA_MEM_WRITE      = 3'b110;
    bus.DATA_MEM_READ       = 4'b1000;
    bus.DATA_MEM_ADDR       = 32'h400;
    bus.DATA_MEM_WRITE_DATA = 32'h1234_5678;
    bus.MEM_READ_DATA       = 32'hCAFE_F00D;
    bus.MEM_BUSYWAIT        = 1'b1;
    tick();
    chk("t4_mem_write", 32'(bus.MEM_WRITE), 32'h6);
    chk("t4_mem_read0", 32'(bus.MEM_READ), 32'h0);
    chk("t4_mem_wdata", bus.MEM_WRITE_DATA, 32'h1234_5678);
    chk("t4_mem_addr", bus.MEM_ADDR, 32'h400);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t4_hold_write", 32'(bus.MEM_WRITE), 32'h6);
      chk("t4_hold_busy", 32'(bus.DATA_MEM_BUSYWAIT), 32'h1);
    end
    bus.MEM_BUSYWAIT = 1'b0;
    tick();
    chk("t4_dbusy_fall", 32'(bus.DATA_MEM_BUSYWAIT), 32'h0);
    chk("t4_write_clr", 32'(bus.MEM_WRITE), 32'h0);
    chk("t4_rdata_kept", bus.DATA_MEM_READ_DATA, 32'hA5A5_A5A5);
    bus.DATA_MEM_WRITE = 3'b000;
    bus.DATA_MEM_READ  = 4'b0000;
    tick();

    // 5. Fetch flushed during I_WAIT, pending data served next
    bus.INSTR_READ    = 1'b1;
    bus.INSTR_ADDR    = 32'h500;
    bus.MEM_BUSYWAIT  = 1'b1;
    bus.MEM_READ_DATA = 32'h0BAD_C0DE;
    tick();
    tick();
    bus.INSTR_READ    = 1'b0;
    bus.DATA_MEM_READ = 4'b1000;
    bus.DATA_MEM_ADDR = 32'h600;
    #1;
    chk("t5_ibusy_flush", 32'(bus.INSTR_MEM_BUSYWAIT), 32'h0);
    tick();
    chk("t5_fetch_held", 32'(bus.MEM_READ), 32'hA);
    bus.MEM_BUSYWAIT = 1'b0;
    tick();
    chk("t5_ibusy_done", 32'(bus.INSTR_MEM_BUSYWAIT), 32'h0);
    chk("t5_instr_data", bus.INSTR_DATA, 32'h0BAD_C0DE);
    tick();
    chk("t5_dbusy_pend", 32'(bus.DATA_MEM_BUSYWAIT), 32'h1);
    tick();
    chk("t5_data_addr", bus.MEM_ADDR, 32'h600);
    chk("t5_data_read", 32'(bus.MEM_READ), 32'h8);
    tick();
    tick();
    chk("t5_dbusy_end", 32'(bus.DATA_MEM_BUSYWAIT), 32'h0);
    bus.DATA_MEM_READ = 4'b0000;
    tick();

    // 6. Reset during D_WAIT, then a fresh request
    bus.DATA_MEM_READ = 4'b1000;
    bus.DATA_MEM_ADDR = 32'h700;
    bus.MEM_BUSYWAIT  = 1'b1;
    tick();
    tick();
    chk("t6_in_wait", 32'(bus.MEM_READ), 32'h8);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_read", 32'(bus.MEM_READ), 32'h0);
    chk("t6_rst_write", 32'(bus.MEM_WRITE), 32'h0);
    bus.DATA_MEM_READ = 4'b0000;
    tick();
    chk("t6_rst_rdata", bus.DATA_MEM_READ_DATA, 32'h0);
    rst_n             = 1'b1;
    bus.MEM_BUSYWAIT  = 1'b0;
    bus.DATA_MEM_READ = 4'b1000;
    bus.DATA_MEM_ADDR = 32'h710;
    bus.MEM_READ_DATA = 32'h7777_7777;
    tick();
    chk("t6_fresh_addr", bus.MEM_ADDR, 32'h710);
    chk("t6_fresh_read", 32'(bus.MEM_READ), 32'h8);
    tick();
    tick();
    chk("t6_dbusy_end", 32'(bus.DATA_MEM_BUSYWAIT), 32'h0);
    chk("t6_data_rdata", bus.DATA_MEM_READ_DATA, 32'h7777_7777);
    bus.DATA_MEM_READ = 4'b0000;
    tick();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
